timer_ctrl: RTL

Upstream control stage for the MM:SS countdown timer. Conditions the raw load and start/pause push-buttons, runs the run/pause/expire state machine, and generates the strobes the counter chain consumes:
- a one-cycle `load` pulse;
- a one-cycle-per-second `ce` count-enable.

It also watches the counter chain's all-zero flag to stop counting and raise the alarm LED.

---
 rtl/timer_ctrl_if.sv | 22 ++
 rtl/timer_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl_if.sv
// Button/zero inputs and strobe/status outputs of the countdown-timer control stage.
// load and ce are single-cycle strobes with no backpressure: a consumer must act on every high cycle.
interface timer_ctrl_if;
   logic       btn_load;
   logic       btn_start;
   logic       zero;
   logic       load;
   logic       ce;
   logic       running;
   logic       alarm;
   logic [2:0] state;

   modport master (
      input  btn_load, btn_start, zero,
      output load, ce, running, alarm, state
   );

   modport slave (
      output btn_load, btn_start, zero,
      input  load, ce, running, alarm, state
   );
endinterface

// File: rtl/timer_ctrl.sv
// Countdown timer control: button conditioning, run/pause/expire FSM, load and 1 Hz ce strobes.
// Optional blinking alarm LED in EXPIRED when TIMER_CTRL_ALARM_BLINK_EN is defined.
module timer_ctrl #(
   parameter int CLK_HZ          = 100_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input logic          clk,
   input logic          reset,
   timer_ctrl_if.master bus
);
   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
`ifdef TIMER_CTRL_ALARM_BLINK_EN
   localparam logic [PW-1:0] HALF_LAST = PW'(CLK_HZ / 2 - 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOADED  = 3'd1,
      S_RUNNING = 3'd2,
      S_PAUSED  = 3'd3,
      S_EXPIRED = 3'd4
   } state_t;

   // Bit 0 is the load button, bit 1 the start/pause button.
   logic [1:0]    w_btn_raw;
   logic [1:0]    r_sync1;
   logic [1:0]    r_sync2;
   logic [1:0]    r_db;
   logic [1:0]    r_db_q;
   logic [DW-1:0] r_db_cnt [2];
   logic [1:0]    w_press;
   logic          w_load_press;
   logic          w_start_press;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [PW-1:0] r_presc;
   logic [PW-1:0] w_presc_nxt;
   logic          r_load;
   logic          r_ce;
   logic          r_running;
   logic          r_alarm;
   logic          w_load_nxt;
   logic          w_ce_nxt;
   logic          w_alarm_nxt;

   assign w_btn_raw = {bus.btn_start, bus.btn_load};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_db    <= '0;
         r_db_q  <= '0;
         for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
      end else begin
         r_sync1 <= w_btn_raw;
         r_sync2 <= r_sync1;
         r_db_q  <= r_db;
         // A level change is accepted only after it persists; any return to the old level restarts.
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_db[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_LAST) begin
               r_db[i]     <= r_sync2[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_press       = r_db & ~r_db_q;
   assign w_load_press  = w_press[0];
   assign w_start_press = w_press[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_presc   <= '0;
         r_load    <= 1'b0;
         r_ce      <= 1'b0;
         r_running <= 1'b0;
         r_alarm   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_presc   <= w_presc_nxt;
         r_load    <= w_load_nxt;
         r_ce      <= w_ce_nxt;
         r_running <= (w_state_nxt == S_RUNNING);
         r_alarm   <= w_alarm_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_presc_nxt = r_presc;
      w_load_nxt  = 1'b0;
      w_ce_nxt    = 1'b0;
      w_alarm_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_load_press) begin
               w_state_nxt = S_LOADED;
               w_load_nxt  = 1'b1;
               w_presc_nxt = '0;
            end
         end
         S_LOADED: begin
            if (w_load_press) begin
               w_load_nxt  = 1'b1;
            end else if (w_start_press && !bus.zero) begin
               w_state_nxt = S_RUNNING;
               w_presc_nxt = '0;
            end
         end
         S_RUNNING: begin
            // Priority: load, then expiry, then pause; ce only while staying in RUNNING.
            if (w_load_press) begin
               w_state_nxt = S_LOADED;
               w_load_nxt  = 1'b1;
               w_presc_nxt = '0;
            end else if (bus.zero) begin
               w_state_nxt = S_EXPIRED;
               w_presc_nxt = '0;
               w_alarm_nxt = 1'b1;
            end else if (w_start_press) begin
               w_state_nxt = S_PAUSED;
            end else if (r_presc == PRESC_MAX) begin
               w_presc_nxt = '0;
               w_ce_nxt    = 1'b1;
            end else begin
               w_presc_nxt = r_presc + 1'b1;
            end
         end
         S_PAUSED: begin
            if (w_load_press) begin
               w_state_nxt = S_LOADED;
               w_load_nxt  = 1'b1;
               w_presc_nxt = '0;
            end else if (w_start_press) begin
               w_state_nxt = S_RUNNING;
            end
         end
         S_EXPIRED: begin
            if (w_load_press) begin
               w_state_nxt = S_LOADED;
               w_load_nxt  = 1'b1;
               w_presc_nxt = '0;
            end else if (w_start_press) begin
               w_state_nxt = S_IDLE;
               w_presc_nxt = '0;
            end else begin
`ifdef TIMER_CTRL_ALARM_BLINK_EN
               if (r_presc == HALF_LAST) begin
                  w_presc_nxt = '0;
                  w_alarm_nxt = ~r_alarm;
               end else begin
                  w_presc_nxt = r_presc + 1'b1;
                  w_alarm_nxt = r_alarm;
               end
`else
               w_alarm_nxt = 1'b1;
`endif
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_presc_nxt = '0;
         end
      endcase
   end

   assign bus.load    = r_load;
   assign bus.ce      = r_ce;
   assign bus.running = r_running;
   assign bus.alarm   = r_alarm;
   assign bus.state   = r_state;
endmodule
